uart_reg_bridge: RTL

UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

---
 rtl/uart_bridge_pkg.sv | 23 ++
 rtl/bridge_timeout.sv | 30 +++
 rtl/uart_reg_bridge.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-register-bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    SEND
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte timeout counter: saturating count while enabled, flags the last cycle.
module bridge_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count up while enabled; hold at LAST so a stalled counter never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// Byte-command bridge: UART write/read commands become single register-bus accesses
// followed by a one-byte response (ACK, read data or NAK).
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_transmit,
  input  logic       tx_ready,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  output logic       busy,
  output logic       overrun
);

  state_t     state, state_next;
  logic       is_write;
  logic [7:0] addr_q, wdata_q, resp_q, resp_next;
  logic       overrun_q;
  logic       latch_op, latch_addr, latch_wdata, load_resp, drop;
  logic       waiting, expired;

  assign waiting = (state == GET_ADDR) || (state == GET_DATA);

  // Counter restarts on entry to a byte-waiting state (it sits cleared elsewhere)
  // and on every byte accepted while waiting.
  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (!waiting || rx_valid),
    .enable (waiting),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and one-cycle strobes; an arriving byte beats timeout expiry.
  always_comb begin
    state_next  = state;
    tx_transmit = 1'b0;
    bus_we      = 1'b0;
    bus_re      = 1'b0;
    latch_op    = 1'b0;
    latch_addr  = 1'b0;
    latch_wdata = 1'b0;
    load_resp   = 1'b0;
    resp_next   = RSP_NAK;
    drop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_opcode(rx_data)) begin
            latch_op   = 1'b1;
            state_next = GET_ADDR;
          end else begin
            load_resp  = 1'b1;
            resp_next  = RSP_NAK;
            state_next = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_valid) begin
          latch_addr = 1'b1;
          state_next = is_write ? GET_DATA : BUS_RD;
        end else if (expired) begin
          state_next = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_valid) begin
          latch_wdata = 1'b1;
          state_next  = BUS_WR;
        end else if (expired) begin
          state_next = IDLE;
        end
      end
      BUS_WR: begin
        drop       = rx_valid;
        bus_we     = 1'b1;
        load_resp  = 1'b1;
        resp_next  = RSP_ACK;
        state_next = SEND;
      end
      BUS_RD: begin
        drop       = rx_valid;
        bus_re     = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        drop       = rx_valid;
        load_resp  = 1'b1;
        resp_next  = bus_rdata;
        state_next = SEND;
      end
      SEND: begin
        drop = rx_valid;
        if (tx_ready) begin
          tx_transmit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command fields, response byte and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_write  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (latch_op)    is_write  <= (rx_data == OP_WRITE);
      if (latch_addr)  addr_q    <= rx_data;
      if (latch_wdata) wdata_q   <= rx_data;
      if (load_resp)   resp_q    <= resp_next;
      if (drop)        overrun_q <= 1'b1;
    end
  end

  assign tx_data   = resp_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign overrun   = overrun_q;

endmodule
